// File: rtl/sens_trace_serializer_if.sv
// sens_trace_serializer_if: sensor FIFO read handshake plus 16-bit valid/ready word stream
//   sens_drdy : request the next FIFO sample (serializer -> FIFO)
//   sens_dvld : FIFO data valid, one cycle (FIFO -> serializer)
//   sens_dout : FIFO data word, 128 bits (FIFO -> serializer)
//   word      : serialised 16-bit word (serializer -> consumer)
//   word_vld  : word is valid (serializer -> consumer)
//   word_rdy  : consumer accepts word (consumer -> serializer)
interface sens_trace_serializer_if;
  logic         sens_drdy;
  logic         sens_dvld;
  logic [127:0] sens_dout;
  logic [15:0]  word;
  logic         word_vld;
  logic         word_rdy;
  modport master (output sens_drdy, word, word_vld, input sens_dvld, sens_dout, word_rdy);
  modport slave  (input sens_drdy, word, word_vld, output sens_dvld, sens_dout, word_rdy);
endinterface

// File: rtl/sens_trace_serializer.sv
// sens_trace_serializer: reads N_SAMPLES sensor samples from the FIFO and streams their SENSOR_WIDTH LSBs MSB-first as 16-bit words
//   clk_i, rst_n      : aes_clk and asynchronous active-low reset
//   start_i           : one-cycle pulse starting a readout (ignored unless idle)
//   bus (master)      : FIFO drdy/dvld/dout handshake and word/word_vld/word_rdy stream
//   busy_o, done_o    : readout in progress / one-cycle end-of-readout pulse
//   smp_cnt_o         : samples fully emitted in the current or last readout
//   timeout_err_o     : sticky, FIFO did not answer within TIMEOUT cycles
//   spur_err_o        : sticky, dvld arrived while not waiting for it
module sens_trace_serializer #(
  parameter int N_SAMPLES    = 128,
  parameter int SENSOR_WIDTH = 32,
  parameter int TIMEOUT      = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_n,
  input  logic                           start_i,
  sens_trace_serializer_if.master        bus,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [15:0]                    smp_cnt_o,
  output logic                           timeout_err_o,
  output logic                           spur_err_o
);
  localparam int WORDS = SENSOR_WIDTH / 16;
  localparam int WW    = WORDS > 1 ? $clog2(WORDS) : 1;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, SHIFT, DONE} state_e;
  state_e                  state_q, state_d;
  logic [SENSOR_WIDTH-1:0] sh_q, sh_d;
  logic [WW-1:0]           wcnt_q, wcnt_d;
  logic [15:0]             scnt_q, scnt_d, tcnt_q, tcnt_d, smp_q, smp_d;
  logic                    tmo_q, tmo_d, spur_q, spur_d;
  logic                    busy_q, done_q, drdy_q, vld_q;
  logic                    unused_dout;
  // only the low SENSOR_WIDTH bits of the FIFO word carry sensor data
  assign unused_dout   = ^bus.sens_dout;
  assign bus.sens_drdy = drdy_q;
  assign bus.word_vld  = vld_q;
  assign bus.word      = sh_q[SENSOR_WIDTH-1 -: 16];
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign smp_cnt_o     = smp_q;
  assign timeout_err_o = tmo_q;
  assign spur_err_o    = spur_q;
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    wcnt_d  = wcnt_q;
    scnt_d  = scnt_q;
    tcnt_d  = tcnt_q;
    smp_d   = smp_q;
    tmo_d   = tmo_q;
    spur_d  = spur_q | (bus.sens_dvld & (state_q != WAIT));
    case (state_q)
      IDLE: if (start_i) begin
        state_d = REQ;
        scnt_d  = '0;
        smp_d   = '0;
        tcnt_d  = '0;
        tmo_d   = 1'b0;
        spur_d  = bus.sens_dvld;
      end
      REQ: begin
        state_d = WAIT;
        tcnt_d  = '0;
      end
      WAIT: if (bus.sens_dvld) begin
        state_d = SHIFT;
        sh_d    = bus.sens_dout[SENSOR_WIDTH-1:0];
        wcnt_d  = '0;
      end else if (tcnt_q == 16'(TIMEOUT - 1)) begin
        state_d = DONE;
        tmo_d   = 1'b1;
      end else begin
        tcnt_d = tcnt_q + 16'd1;
      end
      SHIFT: if (bus.word_rdy) begin
        sh_d   = sh_q << 16;
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == WW'(WORDS - 1)) begin
          smp_d   = smp_q + 16'd1;
          state_d = scnt_q == 16'(N_SAMPLES - 1) ? DONE : REQ;
          scnt_d  = scnt_q == 16'(N_SAMPLES - 1) ? scnt_q : scnt_q + 16'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // status outputs are flops loaded from the next state so no input reaches an output combinationally
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      wcnt_q  <= '0;
      scnt_q  <= '0;
      tcnt_q  <= '0;
      smp_q   <= '0;
      tmo_q   <= 1'b0;
      spur_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drdy_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
      tcnt_q  <= tcnt_d;
      smp_q   <= smp_d;
      tmo_q   <= tmo_d;
      spur_q  <= spur_d;
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == DONE;
      drdy_q  <= state_d == REQ;
      vld_q   <= state_d == SHIFT;
    end
endmodule
